sram_mem_ctrl: RTL
==================

# sram_mem_ctrl

Memory-stage controller consuming the `mem_read`/`mem_write` control bits produced by instruction decode, carried down the pipeline to MEM. It converts one 32-bit load or store into two timed 16-bit accesses on an external SRAM. While the access is in flight it freezes the pipeline, and it returns the load word to write-back.

## Interface
Parameters:
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `ACCESS_CYCLES`, 4: cycles per 16-bit SRAM phase; must be ≥ 1.
- `SRAM_ADDR_W`, 18: SRAM half-word address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: load request. Held stable by the pipeline while `freeze`=1.
- `mem_write` in 1: store request. Held stable while `freeze`=1.
- `address` in 32: byte address from the ALU.
- `wdata` in 32: store data.
- `rdata` out 32: last completed load word, registered.
- `ready` out 1: one-cycle pulse when the access completes.
- `freeze` out 1: pipeline stall.
- `sram_addr` out SRAM_ADDR_W: SRAM half-word address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: drive enable for SRAM data.
- `sram_dq_in` in 16: SRAM read data.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- Word index: `idx = (address - ADDR_BASE) >> 2`, truncated to SRAM_ADDR_W-1 bits. Bits [1:0] of `address` are ignored, and out-of-range addresses wrap silently.
- Half-word addresses: the low half of the word is at `{idx,1'b0}`, the high half at `{idx,1'b1}`.
- States: IDLE, LO, HI, DONE. Transitions:
  - IDLE → LO when `mem_read|mem_write`. The operation is latched at this edge; a write takes priority if both bits are set.
  - LO → HI and HI → DONE after ACCESS_CYCLES cycles each, counted by the phase timer.
  - DONE → IDLE unconditionally.
- Requests are sampled only in IDLE. In DONE the same instruction's request bits may still be high; they are ignored.
- Write behaviour, per phase:
  - `sram_we_n`=0 and `sram_dq_oe`=1 for all ACCESS_CYCLES cycles of the phase.
  - `sram_dq_out` is `wdata[15:0]` in LO and `wdata[31:16]` in HI.
- Read behaviour:
  - `sram_we_n`=1 and `sram_dq_oe`=0.
  - `sram_dq_in` is captured on the last cycle of each phase: LO into `rdata[15:0]`, HI into `rdata[31:16]`.
  - `rdata` changes only on reads and holds its value across writes and idle cycles.
- Outside LO/HI: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
- `freeze` = `(mem_read|mem_write) & ~ready`. This is combinational, so it rises in the same cycle the request appears in IDLE.
- `ready` = (state == DONE).
- No request present (ALU op, branch): `freeze`=0 and no SRAM activity.
- Reset, including mid-access:
  - State goes to IDLE, the counter to 0, `rdata` to 0.
  - `sram_we_n`=1, `sram_dq_oe`=0, `ready`=0.
  - The partial access is abandoned; the SRAM may hold one written half.

## Timing
- Request seen in IDLE at cycle 0:
  - LO occupies cycles 1..N and HI occupies N+1..2N, where N = ACCESS_CYCLES.
  - DONE is cycle 2N+1, with `ready`=1.
- `freeze` is high for cycles 0..2N, i.e. 2N+1 cycles (9 at default). The pipeline advances at the end of cycle 2N+1.
- The load word is valid on `rdata` from cycle 2N+1. WB samples it at that edge.
- Back-to-back memory instructions: the next request is seen in IDLE at cycle 2N+2, so there is no bubble beyond the freeze.
- Phase timer: width `$clog2(ACCESS_CYCLES+1)`. It clears on every state change.

## Structure
- Shared package `mem_pkg`:
  - state enum `mem_state_t` (IDLE, LO, HI, DONE);
  - `DEFAULT_ADDR_BASE`=1024;
  - half-word width constant 16.
- One sub-module, `sram_phase_timer`: a loadable down-counter with `start`, `done`, and a parameter N. It is reused for both phases.

## Test plan
- Store: `mem_write`=1, `address`=1028, `wdata`=0xDEADBEEF.
  - SRAM[2]=0xBEEF and SRAM[3]=0xDEAD.
  - `sram_we_n` low for 4 cycles per half.
  - `freeze` high for 9 cycles, then `ready` for 1 cycle.
- Load: `mem_read`=1, `address`=1028 after the store above.
  - `rdata`=0xDEADBEEF in the DONE cycle.
  - `sram_dq_oe`=0 throughout.
- Back-to-back: store 0x12345678 to 1032, then load 1032 on the next instruction.
  - The two freeze windows are separated by exactly one ready cycle.
  - `rdata`=0x12345678.
- Reset in HI of a load from 1028 (SRAM preloaded).
  - Next cycle: IDLE, `rdata`=0, `freeze` equals the request, `sram_we_n`=1.
  - A retried load returns the correct word.
- Both `mem_read` and `mem_write` =1, `wdata`=0xCAFEF00D.
  - Behaves as a write: SRAM updated, `rdata` unchanged.
- Non-memory op (request bits 0) for 5 cycles, and `address`=1024+2^19 with ACCESS_CYCLES=1.
  - Non-memory op: `freeze`=0, no SRAM toggling.
  - Out-of-range address: the index wraps to 0, and `freeze` lasts 3 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_pkg;

    localparam int unsigned DEFAULT_ADDR_BASE = 1024;
    localparam int unsigned HALF_W            = 16;
    localparam int unsigned WORD_W            = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Operation latched when a request is accepted in IDLE
    typedef struct packed {
        logic              is_write;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing one SRAM phase; done while the count is zero.
module sram_phase_timer #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] count_q;

    // start loads N-1 so done rises on the Nth cycle of the phase
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= CNT_W'(N - 1);
        end else if (clear) begin
            count_q <= '0;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: one 32-bit load/store as two timed 16-bit SRAM phases,
// stalling the pipeline until the access completes.
module sram_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BASE     = DEFAULT_ADDR_BASE,
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter int unsigned SRAM_ADDR_W   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [WORD_W-1:0]      address,
    input  logic [WORD_W-1:0]      wdata,
    output logic [WORD_W-1:0]      rdata,
    output logic                   ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [HALF_W-1:0]      sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [HALF_W-1:0]      sram_dq_in,
    output logic                   sram_we_n
);

    localparam int unsigned IDX_W = SRAM_ADDR_W - 1;

    mem_state_t             state_q, state_d;
    mem_req_t               req_q, req_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]      rdata_d;
    logic                   ready_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_d;
    logic [HALF_W-1:0]      sram_dq_out_d;
    logic                   sram_dq_oe_d;
    logic                   sram_we_n_d;
    logic                   timer_start;
    logic                   timer_clear;
    logic                   phase_done;

    // Word index relative to the SRAM window; out-of-range wraps silently
    logic [WORD_W-1:0] addr_off;
    logic [IDX_W-1:0]  word_idx;
    logic              unused_addr_bits;

    assign addr_off         = address - WORD_W'(ADDR_BASE);
    assign word_idx         = addr_off[IDX_W+1:2];
    assign unused_addr_bits = ^{addr_off[WORD_W-1:IDX_W+2], addr_off[1:0]};

    sram_phase_timer #(
        .N(ACCESS_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .clear (timer_clear),
        .done  (phase_done)
    );

    // Next-state, read capture and next-cycle SRAM pin values
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        idx_d         = idx_q;
        rdata_d       = rdata;
        timer_start   = 1'b0;
        timer_clear   = 1'b0;
        sram_addr_d   = '0;
        sram_dq_out_d = '0;
        sram_dq_oe_d  = 1'b0;
        sram_we_n_d   = 1'b1;
        ready_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    state_d        = LO;
                    req_d.is_write = mem_write;
                    req_d.wdata    = wdata;
                    idx_d          = word_idx;
                    timer_start    = 1'b1;
                end
            end
            LO: begin
                if (phase_done) begin
                    state_d     = HI;
                    timer_start = 1'b1;
                    if (!req_q.is_write) begin
                        rdata_d[HALF_W-1:0] = sram_dq_in;
                    end
                end
            end
            HI: begin
                if (phase_done) begin
                    state_d = DONE;
                    if (!req_q.is_write) begin
                        rdata_d[WORD_W-1:HALF_W] = sram_dq_in;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        timer_clear = (state_d != state_q) && !timer_start;

        if (state_d == LO || state_d == HI) begin
            sram_addr_d = {idx_d, (state_d == HI)};
            if (req_d.is_write) begin
                sram_we_n_d   = 1'b0;
                sram_dq_oe_d  = 1'b1;
                sram_dq_out_d = (state_d == HI) ? req_d.wdata[WORD_W-1:HALF_W]
                                                : req_d.wdata[HALF_W-1:0];
            end
        end

        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            idx_q       <= '0;
            rdata       <= '0;
            ready       <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            idx_q       <= idx_d;
            rdata       <= rdata_d;
            ready       <= ready_d;
            sram_addr   <= sram_addr_d;
            sram_dq_out <= sram_dq_out_d;
            sram_dq_oe  <= sram_dq_oe_d;
            sram_we_n   <= sram_we_n_d;
        end
    end

    // Stall must rise in the same cycle the request appears
    assign freeze = (mem_read | mem_write) & ~ready;

endmodule
